// File: rtl/uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// uart_host_ctrl
//
// Host-side initiator for the Core_UART parallel bus. Converts a valid/ready
// TX byte stream into single-cycle UART write strobes. Converts UART receive
// events into a valid/ready RX stream backed by one holding register, because
// Core_UART has no FIFOs of its own. Also drives the static line
// configuration and keeps sticky error flags.
//
// Ports
//   CLK, RESET             clock, synchronous active-high reset
//   tx_data/valid/ready    TX byte stream in (tx_ready is combinational)
//   rx_data/err/valid/ready RX byte stream out, err = {framing, parity}
//   err_clr                clears ovf/par/frm sticky flags
//   ovf/par/frm_sticky     sticky error indications
//   UART_BAUD_VAL, UART_BIT8, UART_PARITY_EN, UART_ODD_N_EVEN
//                          static configuration, taken from the parameters
//   UART_CSN/WEN/OEN       registered active-low bus strobes
//   UART_DATA_IN           registered write data to the UART
//   UART_DATA_OUT          read data from the UART
//   UART_TXRDY/RXRDY/OVERFLOW/PARITY_ERR/FRAMING_ERR
//                          UART status inputs
// ---------------------------------------------------------------------------
module uart_host_ctrl #(
   parameter logic [12:0] BAUD_DIV   = 13'd53,
   parameter bit          BIT8       = 1'b1,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          ODD_N_EVEN = 1'b0,
   parameter int          RD_HOLD    = 2,
   parameter int          TX_GUARD   = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   // TX stream
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   // RX stream
   output logic [7:0]  rx_data,
   output logic [1:0]  rx_err,
   output logic        rx_valid,
   input  logic        rx_ready,
   // error flags
   input  logic        err_clr,
   output logic        ovf_sticky,
   output logic        par_sticky,
   output logic        frm_sticky,
   // static UART configuration
   output logic [12:0] UART_BAUD_VAL,
   output logic        UART_BIT8,
   output logic        UART_PARITY_EN,
   output logic        UART_ODD_N_EVEN,
   // UART parallel bus
   output logic        UART_CSN,
   output logic        UART_WEN,
   output logic        UART_OEN,
   output logic [7:0]  UART_DATA_IN,
   input  logic [7:0]  UART_DATA_OUT,
   input  logic        UART_TXRDY,
   input  logic        UART_RXRDY,
   input  logic        UART_OVERFLOW,
   input  logic        UART_PARITY_ERR,
   input  logic        UART_FRAMING_ERR
);

   // Shared counter for the read hold, the write guard and the post-read wait.
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_GUARD,
      S_RD,
      S_RD_DONE
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_csn;
   logic               r_wen;
   logic               r_oen;
   logic [7:0]         r_data_in;
   logic [7:0]         r_rx_data;
   logic [1:0]         r_rx_err;
   logic               r_rx_valid;
   logic               r_ovf;
   logic               r_par;
   logic               r_frm;

   logic               w_rd_req;
   logic               w_tx_ready;
   logic               w_tx_fire;
   logic               w_rx_fire;
   logic               w_rd_last;
   logic [7:0]         w_rx_byte;

   // A read is only worth issuing when the holding register is free; if it
   // is occupied the byte stays in the UART and OVERFLOW reports any loss.
   assign w_rd_req   = UART_RXRDY & ~r_rx_valid;

   // Reads win over writes, so a pending read masks tx_ready.
   assign w_tx_ready = (r_state == S_IDLE) & UART_TXRDY & ~w_rd_req;
   assign w_tx_fire  = tx_valid & w_tx_ready;
   assign w_rx_fire  = r_rx_valid & rx_ready;
   assign w_rd_last  = (r_state == S_RD) && (r_cnt == CNT_W'(RD_HOLD - 1));

   // In 7-bit mode the UART's bit 7 is not part of the character.
   assign w_rx_byte  = BIT8 ? UART_DATA_OUT : {1'b0, UART_DATA_OUT[6:0]};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_csn      <= 1'b1;
         r_wen      <= 1'b1;
         r_oen      <= 1'b1;
         r_data_in  <= 8'h00;
         r_rx_data  <= 8'h00;
         r_rx_err   <= 2'b00;
         r_rx_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_par      <= 1'b0;
         r_frm      <= 1'b0;
      end else begin
         // A set in the same cycle as err_clr keeps the flag set.
         r_ovf <= UART_OVERFLOW | (r_ovf & ~err_clr);
         r_par <= (w_rd_last & UART_PARITY_ERR)  | (r_par & ~err_clr);
         r_frm <= (w_rd_last & UART_FRAMING_ERR) | (r_frm & ~err_clr);

         if (w_rx_fire) begin
            r_rx_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_rd_req) begin
                  r_state <= S_RD;
                  r_csn   <= 1'b0;
                  r_oen   <= 1'b0;
                  r_cnt   <= '0;
               end else if (w_tx_fire) begin
                  r_state   <= S_WR;
                  r_csn     <= 1'b0;
                  r_wen     <= 1'b0;
                  r_data_in <= tx_data;
               end
            end

            // Single-cycle write strobe.
            S_WR: begin
               r_state <= S_WR_GUARD;
               r_csn   <= 1'b1;
               r_wen   <= 1'b1;
               r_cnt   <= '0;
            end

            // TXRDY lags the write inside the UART, so it is not trusted
            // until the guard interval has elapsed.
            S_WR_GUARD: begin
               if (r_cnt == CNT_W'(TX_GUARD - 1)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // OEN held low RD_HOLD cycles; data sampled on the last one.
            S_RD: begin
               if (w_rd_last) begin
                  r_state    <= S_RD_DONE;
                  r_csn      <= 1'b1;
                  r_oen      <= 1'b1;
                  r_cnt      <= '0;
                  r_rx_data  <= w_rx_byte;
                  r_rx_err   <= {UART_FRAMING_ERR, UART_PARITY_ERR};
                  r_rx_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // Give RXRDY time to fall so the same byte is not read twice;
            // bounded at four cycles in case it never drops.
            S_RD_DONE: begin
               if (!UART_RXRDY || (r_cnt == CNT_W'(3))) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_csn   <= 1'b1;
               r_wen   <= 1'b1;
               r_oen   <= 1'b1;
            end
         endcase
      end
   end

   assign tx_ready        = w_tx_ready;
   assign rx_data         = r_rx_data;
   assign rx_err          = r_rx_err;
   assign rx_valid        = r_rx_valid;
   assign ovf_sticky      = r_ovf;
   assign par_sticky      = r_par;
   assign frm_sticky      = r_frm;

   assign UART_BAUD_VAL   = BAUD_DIV;
   assign UART_BIT8       = BIT8;
   assign UART_PARITY_EN  = PARITY_EN;
   assign UART_ODD_N_EVEN = ODD_N_EVEN;

   assign UART_CSN        = r_csn;
   assign UART_WEN        = r_wen;
   assign UART_OEN        = r_oen;
   assign UART_DATA_IN    = r_data_in;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_host_ctrl
//
// Bench for uart_host_ctrl. A bus-timeline model tracks, in absolute cycle
// numbers, when the next write strobe, read window and idle point occur, and
// is compared against every DUT output on every falling edge. Directed
// sequences pin the model with literal expectations; a randomized phase
// exercises everything together.
// ---------------------------------------------------------------------------
module tb_uart_host_ctrl;

   localparam int RD_HOLD  = 2;
   localparam int TX_GUARD = 2;
   localparam bit BIT8     = 1'b1;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic [1:0]  rx_err;
   logic        rx_valid;
   logic        rx_ready;
   logic        err_clr;
   logic        ovf_sticky, par_sticky, frm_sticky;
   logic [12:0] UART_BAUD_VAL;
   logic        UART_BIT8, UART_PARITY_EN, UART_ODD_N_EVEN;
   logic        UART_CSN, UART_WEN, UART_OEN;
   logic [7:0]  UART_DATA_IN;
   logic [7:0]  UART_DATA_OUT;
   logic        UART_TXRDY, UART_RXRDY, UART_OVERFLOW;
   logic        UART_PARITY_ERR, UART_FRAMING_ERR;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   uart_host_ctrl #(
      .BAUD_DIV   (13'd53),
      .BIT8       (BIT8),
      .PARITY_EN  (1'b0),
      .ODD_N_EVEN (1'b0),
      .RD_HOLD    (RD_HOLD),
      .TX_GUARD   (TX_GUARD)
   ) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .rx_data          (rx_data),
      .rx_err           (rx_err),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .err_clr          (err_clr),
      .ovf_sticky       (ovf_sticky),
      .par_sticky       (par_sticky),
      .frm_sticky       (frm_sticky),
      .UART_BAUD_VAL    (UART_BAUD_VAL),
      .UART_BIT8        (UART_BIT8),
      .UART_PARITY_EN   (UART_PARITY_EN),
      .UART_ODD_N_EVEN  (UART_ODD_N_EVEN),
      .UART_CSN         (UART_CSN),
      .UART_WEN         (UART_WEN),
      .UART_OEN         (UART_OEN),
      .UART_DATA_IN     (UART_DATA_IN),
      .UART_DATA_OUT    (UART_DATA_OUT),
      .UART_TXRDY       (UART_TXRDY),
      .UART_RXRDY       (UART_RXRDY),
      .UART_OVERFLOW    (UART_OVERFLOW),
      .UART_PARITY_ERR  (UART_PARITY_ERR),
      .UART_FRAMING_ERR (UART_FRAMING_ERR)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // -------------------------------------------------------------------------
   // Bus-timeline model: cycle numbers of the write strobe, read window start
   // and the first idle cycle, plus the architectural flag/holding values.
   // -------------------------------------------------------------------------
   int         cyc       = 0;
   int         m_free    = 0;
   int         m_wr_at   = -10;
   int         m_rd_from = -10;
   bit         m_rd      = 1'b0;
   logic [7:0] m_din     = 8'h00;
   logic [7:0] m_rxd     = 8'h00;
   logic [1:0] m_rxe     = 2'b00;
   bit         m_rxv     = 1'b0;
   bit         m_ovf     = 1'b0;
   bit         m_par     = 1'b0;
   bit         m_frm     = 1'b0;
   bit         e_lo_wr, e_lo_rd, e_idle, e_txr, e_cap, e_start_rd, e_start_wr;

   always @(negedge CLK) begin
      e_lo_wr = (cyc == m_wr_at);
      e_lo_rd = m_rd && (cyc >= m_rd_from) && (cyc < m_rd_from + RD_HOLD);
      e_idle  = !m_rd && (cyc >= m_free);
      e_txr   = e_idle && UART_TXRDY && !(UART_RXRDY && !m_rxv);

      chk("m_tx_ready", tx_ready, e_txr);
      chk("m_csn", UART_CSN, !(e_lo_wr || e_lo_rd));
      chk("m_wen", UART_WEN, !e_lo_wr);
      chk("m_oen", UART_OEN, !e_lo_rd);
      chk("m_data_in", UART_DATA_IN, m_din);
      chk("m_rx_valid", rx_valid, m_rxv);
      chk("m_rx_data", rx_data, m_rxd);
      chk("m_rx_err", rx_err, m_rxe);
      chk("m_ovf", ovf_sticky, m_ovf);
      chk("m_par", par_sticky, m_par);
      chk("m_frm", frm_sticky, m_frm);

      if (RESET) begin
         m_rd    = 1'b0;
         m_free  = cyc + 1;
         m_wr_at = -10;
         m_din   = 8'h00;
         m_rxd   = 8'h00;
         m_rxe   = 2'b00;
         m_rxv   = 1'b0;
         m_ovf   = 1'b0;
         m_par   = 1'b0;
         m_frm   = 1'b0;
      end else begin
         e_cap      = m_rd && (cyc == m_rd_from + RD_HOLD - 1);
         e_start_rd = e_idle && UART_RXRDY && !m_rxv;
         e_start_wr = e_idle && !e_start_rd && tx_valid && UART_TXRDY;
         m_ovf = UART_OVERFLOW || (m_ovf && !err_clr);
         m_par = (e_cap && UART_PARITY_ERR)  || (m_par && !err_clr);
         m_frm = (e_cap && UART_FRAMING_ERR) || (m_frm && !err_clr);
         if (m_rxv && rx_ready) m_rxv = 1'b0;
         if (e_cap) begin
            m_rxd = BIT8 ? UART_DATA_OUT : {1'b0, UART_DATA_OUT[6:0]};
            m_rxe = {UART_FRAMING_ERR, UART_PARITY_ERR};
            m_rxv = 1'b1;
         end
         // post-read wait: ends when RXRDY is low or on its fourth cycle
         if (m_rd && (cyc >= m_rd_from + RD_HOLD) &&
             (!UART_RXRDY || (cyc == m_rd_from + RD_HOLD + 3))) begin
            m_rd   = 1'b0;
            m_free = cyc + 1;
         end
         if (e_start_rd) begin
            m_rd      = 1'b1;
            m_rd_from = cyc + 1;
         end
         if (e_start_wr) begin
            m_wr_at = cyc + 1;
            m_din   = tx_data;
            m_free  = cyc + 2 + TX_GUARD;
         end
      end
      cyc++;
   end

   // Log of every write strobe actually seen on the bus.
   logic [7:0] wr_log[$];
   always @(negedge CLK) begin
      if (UART_CSN === 1'b0 && UART_WEN === 1'b0) wr_log.push_back(UART_DATA_IN);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      logic [7:0] bytes [16];
      int  t_rd, t_wr, idx, lows;
      bit  found, acc;

      RESET = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      UART_DATA_OUT = 8'h00; UART_TXRDY = 1'b0; UART_RXRDY = 1'b0; UART_OVERFLOW = 1'b0;
      UART_PARITY_ERR = 1'b0; UART_FRAMING_ERR = 1'b0;

      // Reset state and static configuration
      repeat (3) step();
      @(negedge CLK);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_csn", UART_CSN, 1);
      chk("rst_wen", UART_WEN, 1);
      chk("rst_oen", UART_OEN, 1);
      chk("rst_stickies", {ovf_sticky, par_sticky, frm_sticky}, 3'b000);
      chk("cfg_baud", UART_BAUD_VAL, 13'd53);
      chk("cfg_bits", {UART_BIT8, UART_PARITY_EN, UART_ODD_N_EVEN}, 3'b100);
      step(); RESET = 1'b0;

      // Single write of 0xA5
      step(); tx_valid = 1'b1; tx_data = 8'hA5; UART_TXRDY = 1'b1;
      @(negedge CLK);
      chk("a5_accept", tx_ready, 1);
      step(); tx_valid = 1'b0;
      @(negedge CLK);
      chk("a5_csn", UART_CSN, 0);
      chk("a5_wen", UART_WEN, 0);
      chk("a5_oen", UART_OEN, 1);
      chk("a5_data", UART_DATA_IN, 8'hA5);
      chk("a5_busy_wr", tx_ready, 0);
      for (int g = 0; g < TX_GUARD; g++) begin
         step();
         @(negedge CLK);
         chk("a5_busy_guard", tx_ready, 0);
         chk("a5_wen_high", UART_WEN, 1);
      end
      step();
      @(negedge CLK);
      chk("a5_ready_again", tx_ready, 1);

      // Read of 0x3C held with rx_ready low
      step(); UART_TXRDY = 1'b0; UART_RXRDY = 1'b1; UART_DATA_OUT = 8'h3C; rx_ready = 1'b0;
      @(negedge CLK);
      chk("3c_oen_pre", UART_OEN, 1);
      step(); @(negedge CLK);
      chk("3c_oen_lo1", UART_OEN, 0);
      chk("3c_csn_lo1", UART_CSN, 0);
      step(); @(negedge CLK);
      chk("3c_oen_lo2", UART_OEN, 0);
      step(); @(negedge CLK);
      chk("3c_oen_hi", UART_OEN, 1);
      chk("3c_valid", rx_valid, 1);
      chk("3c_data", rx_data, 8'h3C);
      chk("3c_err", rx_err, 2'b00);
      lows = 0;
      for (int k = 0; k < 10; k++) begin
         step(); @(negedge CLK);
         if (UART_OEN == 1'b0) lows++;
         chk("3c_held", rx_valid, 1);
      end
      chk("3c_no_second_read", 16'(lows), 16'd0);
      step(); UART_RXRDY = 1'b0; rx_ready = 1'b1;
      @(negedge CLK);
      step(); rx_ready = 1'b0;
      @(negedge CLK);
      chk("3c_released", rx_valid, 0);

      // RXRDY and tx_valid together: read first, then write
      step(); UART_RXRDY = 1'b1; UART_DATA_OUT = 8'h11; tx_valid = 1'b1; tx_data = 8'h77;
      UART_TXRDY = 1'b1; rx_ready = 1'b1;
      t_rd = -1; t_wr = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (UART_OEN == 1'b0 && t_rd < 0) t_rd = k;
         if (UART_WEN == 1'b0 && t_wr < 0) t_wr = k;
         acc = tx_valid && tx_ready;
         step();
         if (t_rd >= 0) UART_RXRDY = 1'b0;
         if (acc) tx_valid = 1'b0;
      end
      UART_TXRDY = 1'b0; rx_ready = 1'b0;
      chk("order_rd_cycle", 16'(t_rd), 16'd1);
      chk("order_wr_cycle", 16'(t_wr), 16'd5);
      chk("order_rx_data", rx_data, 8'h11);

      // Parity error capture, overflow, err_clr
      step(); UART_RXRDY = 1'b1; UART_PARITY_ERR = 1'b1; UART_FRAMING_ERR = 1'b0;
      UART_DATA_OUT = 8'h5A;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge CLK);
         if (rx_valid) found = 1'b1;
         else step();
      end
      chk("par_wait", found, 1);
      chk("par_rx_err", rx_err, 2'b01);
      chk("par_rx_data", rx_data, 8'h5A);
      chk("par_sticky", par_sticky, 1);
      chk("par_frm_sticky", frm_sticky, 0);
      step(); UART_RXRDY = 1'b0; UART_PARITY_ERR = 1'b0; UART_OVERFLOW = 1'b1;
      @(negedge CLK);
      step(); UART_OVERFLOW = 1'b0;
      @(negedge CLK);
      chk("ovf_sticky", ovf_sticky, 1);
      chk("par_kept", par_sticky, 1);
      step(); err_clr = 1'b1;
      @(negedge CLK);
      step(); err_clr = 1'b0;
      @(negedge CLK);
      chk("clr_all", {ovf_sticky, par_sticky, frm_sticky}, 3'b000);
      step(); err_clr = 1'b1; UART_OVERFLOW = 1'b1;
      @(negedge CLK);
      step(); err_clr = 1'b0; UART_OVERFLOW = 1'b0;
      @(negedge CLK);
      chk("set_wins_ovf", ovf_sticky, 1);
      step(); err_clr = 1'b1; rx_ready = 1'b1;
      @(negedge CLK);
      step(); err_clr = 1'b0; rx_ready = 1'b0;

      // Reset in the middle of a read
      step(); UART_RXRDY = 1'b1; UART_DATA_OUT = 8'hE7;
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge CLK);
         if (UART_OEN == 1'b0) found = 1'b1;
         else step();
      end
      chk("rst_rd_wait", found, 1);
      step(); RESET = 1'b1; UART_RXRDY = 1'b0;
      @(negedge CLK);
      step(); RESET = 1'b0;
      @(negedge CLK);
      chk("rst_rd_csn", UART_CSN, 1);
      chk("rst_rd_oen", UART_OEN, 1);
      chk("rst_rd_valid", rx_valid, 0);
      chk("rst_rd_data", rx_data, 8'h00);

      // 16 back-to-back bytes with TXRDY toggling
      foreach (bytes[i]) bytes[i] = 8'($urandom);
      step();
      wr_log.delete();
      idx = 0;
      for (int k = 0; k < 400 && idx < 16; k++) begin
         step();
         tx_valid = 1'b1; tx_data = bytes[idx]; UART_TXRDY = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (tx_ready) idx++;
      end
      step(); tx_valid = 1'b0; UART_TXRDY = 1'b0;
      repeat (6) step();
      chk("b16_accepted", 16'(idx), 16'd16);
      chk("b16_strobes", 16'(wr_log.size()), 16'd16);
      for (int i = 0; i < 16; i++) begin
         chk("b16_order", (i < wr_log.size()) ? wr_log[i] : 8'hxx, bytes[i]);
      end

      // Randomized traffic, checked cycle by cycle by the model
      for (int k = 0; k < 3000; k++) begin
         step();
         tx_valid         = 1'($urandom_range(0, 1));
         tx_data          = 8'($urandom);
         UART_TXRDY       = ($urandom_range(0, 3) != 0);
         UART_RXRDY       = ($urandom_range(0, 2) == 0);
         UART_DATA_OUT    = 8'($urandom);
         UART_PARITY_ERR  = ($urandom_range(0, 7) == 0);
         UART_FRAMING_ERR = ($urandom_range(0, 7) == 0);
         UART_OVERFLOW    = ($urandom_range(0, 31) == 0);
         err_clr          = ($urandom_range(0, 15) == 0);
         rx_ready         = 1'($urandom_range(0, 1));
         RESET            = ($urandom_range(0, 399) == 0);
      end
      step();
      RESET = 1'b0; tx_valid = 1'b0; UART_TXRDY = 1'b0; UART_RXRDY = 1'b0;
      UART_OVERFLOW = 1'b0; err_clr = 1'b0; rx_ready = 1'b1;
      repeat (10) step();
      @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
